// File: rtl/sync_pkg.sv
// sync_pkg -- shared defaults, legal minimums and sizing helper for sync_debounce (rev 1.0)
`default_nettype none

package sync_pkg;

  localparam int WIDTH_DEFAULT           = 8;
  localparam int WIDTH_MIN               = 1;
  localparam int STAGES_DEFAULT          = 2;
  localparam int STAGES_MIN              = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int DEBOUNCE_CYCLES_MIN     = 2;

  // Stability counter width: max(1, clog2(cycles)).
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_chan.sv
// sync_chan -- one channel: synchronizer chain, optional stability filter, edge pulses (rev 1.0)
// Filter compiled in when SYNC_DEBOUNCE_FILTER_EN is defined.
`default_nettype none

module sync_chan
  import sync_pkg::*;
#(
  parameter int STAGES          = STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              sync;
  logic              out_q;
  logic              out_d;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
    end
  end

  assign sync = sync_q[STAGES-1];

`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any cycle where sync agrees with out restarts the stability window.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (sync != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign out_d = sync;
`endif

  // Edge pulses are derived from next-state so they align with the new out level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

`default_nettype wire

// File: rtl/sync_debounce.sv
// sync_debounce -- WIDTH independent synchronize/debounce channels with rise/fall pulses (rev 1.0)
// Filter compiled in when SYNC_DEBOUNCE_FILTER_EN is defined.
`default_nettype none

module sync_debounce
  import sync_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEFAULT,
  parameter int STAGES          = STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < STAGES_MIN) begin : g_bad_stages
    $error("sync_debounce: STAGES=%0d below minimum %0d", STAGES, STAGES_MIN);
  end

  if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_debounce
    $error("sync_debounce: DEBOUNCE_CYCLES=%0d below minimum %0d",
           DEBOUNCE_CYCLES, DEBOUNCE_CYCLES_MIN);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_chan #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .in_i   (in[i]),
      .out_o  (out[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce -- self-checking bench for sync_debounce (rev 1.0)
// Expectations adapt to whether SYNC_DEBOUNCE_FILTER_EN is defined.
`default_nettype none

module tb_sync_debounce;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;
`ifdef SYNC_DEBOUNCE_FILTER_EN
  localparam int LAT = S + D;
`else
  localparam int LAT = S + 1;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic [W-1:0] drise;
  logic [W-1:0] dfall;

  int checks;
  int errors;
  int mon_checks;
  int mon_errors;

  sync_debounce #(
    .WIDTH           (W),
    .STAGES          (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .out   (dout),
    .rise  (drise),
    .fall  (dfall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sync is the input sampled S edges ago; out follows sync once
  // sync has disagreed with out on D consecutive edges (every edge when unfiltered).
  logic [W-1:0] m_hist [S];
  int           m_run [W];
  int           m_run_nxt [W];
  logic [W-1:0] m_out, m_nxt, m_rise, m_fall;

  always_comb begin
    m_nxt = m_out;
    for (int i = 0; i < W; i++) begin
      m_run_nxt[i] = 0;
      if (m_hist[S-1][i] != m_out[i]) begin
`ifdef SYNC_DEBOUNCE_FILTER_EN
        if (m_run[i] + 1 >= D) m_nxt[i] = m_hist[S-1][i];
        else                   m_run_nxt[i] = m_run[i] + 1;
`else
        m_nxt[i] = m_hist[S-1][i];
`endif
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < S; k++) m_hist[k] <= '0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
      m_out  <= '0;
      m_rise <= '0;
      m_fall <= '0;
    end else begin
      m_hist[0] <= din;
      for (int k = 1; k < S; k++) m_hist[k] <= m_hist[k-1];
      for (int i = 0; i < W; i++) m_run[i] <= m_run_nxt[i];
      m_out  <= m_nxt;
      m_rise <= m_nxt & ~m_out;
      m_fall <= ~m_nxt & m_out;
    end
  end

  // Every cycle: no simultaneous rise/fall and no pulse longer than one cycle.
  logic [W-1:0] prev_rise, prev_fall;
  initial begin
    mon_checks = 0;
    mon_errors = 0;
  end
  always @(negedge clk) begin
    prev_rise <= drise;
    prev_fall <= dfall;
    if (reset === 1'b1) begin
      mon_checks <= mon_checks + 2;
      mon_errors <= mon_errors + int'(|(drise & dfall))
                               + int'(|((drise & prev_rise) | (dfall & prev_fall)));
      if (|(drise & dfall))
        $display("FAIL rise_fall_overlap: rise=%b fall=%b required disjoint", drise, dfall);
      if (|((drise & prev_rise) | (dfall & prev_fall)))
        $display("FAIL pulse_width: rise=%b/%b fall=%b/%b (prev/now) required single cycle",
                 prev_rise, drise, prev_fall, dfall);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    din   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    din   = 4'b1011;
    repeat (5) @(negedge clk);
    checks++;
    if (dout !== 4'b0000 || drise !== 4'b0000 || dfall !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: out=%b rise=%b fall=%b required all 0", dout, drise, dfall);
    end
    reset = 1'b1;
    din   = '0;
  endtask

  task automatic test_single_rise(input logic [W-1:0] pat);
    logic [W-1:0] eo, er;
    do_reset();
    din = pat;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      eo = (k >= LAT) ? pat : '0;
      er = (k == LAT) ? pat : '0;
      checks++;
      if (dout !== eo || drise !== er || dfall !== 4'b0000) begin
        errors++;
        $display("FAIL single_rise[%b] edge%0d: out=%b rise=%b fall=%b required out=%b rise=%b fall=0000",
                 pat, k, dout, drise, dfall, eo, er);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (3) @(negedge clk);
    din = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) din = 4'b0000;
      checks++;
      if (dout !== m_out || drise !== m_rise || dfall !== m_fall) begin
        errors++;
        $display("FAIL glitch_model edge%0d: out=%b rise=%b fall=%b required out=%b rise=%b fall=%b",
                 k, dout, drise, dfall, m_out, m_rise, m_fall);
      end
`ifdef SYNC_DEBOUNCE_FILTER_EN
      checks++;
      if (dout !== 4'b0000 || drise !== 4'b0000 || dfall !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_filtered edge%0d: out=%b rise=%b fall=%b required all 0",
                 k, dout, drise, dfall);
      end
`endif
    end
    // A sustained change afterwards must take the full latency (counter restarted).
    din = 4'b0010;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (dout[1] !== (k >= LAT) || drise[1] !== (k == LAT)) begin
        errors++;
        $display("FAIL glitch_recover edge%0d: out1=%b rise1=%b required out1=%b rise1=%b",
                 k, dout[1], drise[1], (k >= LAT), (k == LAT));
      end
    end
  endtask

  task automatic test_all_channels();
    logic [W-1:0] eo, er, ef;
    do_reset();
    din = 4'b1111;
    for (int k = 1; k <= 10 + LAT + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      eo = (k >= LAT && k < 10 + LAT) ? 4'b1111 : 4'b0000;
      er = (k == LAT) ? 4'b1111 : 4'b0000;
      ef = (k == 10 + LAT) ? 4'b1111 : 4'b0000;
      checks++;
      if (dout !== eo || drise !== er || dfall !== ef) begin
        errors++;
        $display("FAIL all_channels edge%0d: out=%b rise=%b fall=%b required out=%b rise=%b fall=%b",
                 k, dout, drise, dfall, eo, er, ef);
      end
      if (k == 10) din = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] eo, er;
    do_reset();
    din = 4'b1010;
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (dout !== 4'b1010) begin
      errors++;
      $display("FAIL midreset_setup: out=%b required 1010", dout);
    end
    din = 4'b0101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (dout !== 4'b0000 || drise !== 4'b0000 || dfall !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async: out=%b rise=%b fall=%b required all 0", dout, drise, dfall);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 4'b0000 || drise !== 4'b0000 || dfall !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_hold: out=%b rise=%b fall=%b required all 0", dout, drise, dfall);
    end
    reset = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      eo = (k >= LAT) ? 4'b0101 : 4'b0000;
      er = (k == LAT) ? 4'b0101 : 4'b0000;
      checks++;
      if (dout !== eo || drise !== er || dfall !== 4'b0000) begin
        errors++;
        $display("FAIL midreset_release edge%0d: out=%b rise=%b fall=%b required out=%b rise=%b fall=0000",
                 k, dout, drise, dfall, eo, er);
      end
    end
  endtask

  task automatic test_random();
    int hold [W];
    do_reset();
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 2 * D + 2);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if (dout !== m_out || drise !== m_rise || dfall !== m_fall) begin
        errors++;
        $display("FAIL random cycle%0d: out=%b rise=%b fall=%b required out=%b rise=%b fall=%b",
                 c, dout, drise, dfall, m_out, m_rise, m_fall);
      end
      for (int i = 0; i < W; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          din[i]  = ~din[i];
          hold[i] = $urandom_range(1, 2 * D + 2);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    din    = '0;
    test_reset();
    test_single_rise(4'b0001);
    test_single_rise(4'b0100);
    test_glitch();
    test_all_channels();
    test_reset_mid_count();
    test_random();
    @(negedge clk);
    #1;
    checks += mon_checks;
    errors += mon_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter WIDTH, default 8, is the number of independent asynchronous input channels.
REQ-002 Parameter STAGES, default 2, is the synchronizer flop count per channel; legal minimum 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, is the consecutive-cycle stability count; legal minimum 2.
REQ-004 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port in  input  WIDTH  asynchronous level inputs, one bit per channel.
REQ-007 Port out  output  WIDTH  synchronized, filtered level per channel.
REQ-008 Port rise  output  WIDTH  one-cycle pulse on each 0->1 transition of out.
REQ-009 Port fall  output  WIDTH  one-cycle pulse on each 1->0 transition of out.

Function
REQ-010 Each channel SHALL pass in[i] through a chain of exactly STAGES flops; sync[i] is the last stage.
REQ-011 Each channel SHALL have a counter of width max(1, $clog2(DEBOUNCE_CYCLES)).
REQ-012 If sync[i] == out[i], the counter SHALL clear to 0 on that edge.
REQ-013 If sync[i] != out[i] and the counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-014 If sync[i] != out[i] and the counter == DEBOUNCE_CYCLES-1, out[i] SHALL take sync[i] and the counter SHALL clear.
REQ-015 A level change on in[i] held stable SHALL appear on out[i] at posedge STAGES+DEBOUNCE_CYCLES, counting the first posedge after the change as 1.
REQ-016 A pulse on sync[i] shorter than DEBOUNCE_CYCLES cycles SHALL NOT change out[i] and SHALL leave the counter at 0 once sync[i] returns.
REQ-017 rise[i] SHALL be registered and high for exactly the one cycle in which out[i] first reads 1 after reading 0.
REQ-018 fall[i] SHALL be registered and high for exactly the one cycle in which out[i] first reads 0 after reading 1.
REQ-019 rise[i] and fall[i] SHALL never be high in the same cycle.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on any subset SHALL each follow REQ-012..REQ-018.
REQ-021 Counters SHALL never wrap.

Reset
REQ-022 While reset is low, all synchronizer flops, counters, out, rise and fall SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-count SHALL discard the count; no rise or fall pulse SHALL be produced by the reset itself.
REQ-024 After reset deasserts, an in[i] already high SHALL produce out[i]=1 and one rise[i] pulse per REQ-015.

Configuration
REQ-025 Macro SYNC_DEBOUNCE_FILTER_EN, when defined, SHALL compile in the counters and REQ-012..REQ-016 behaviour.
REQ-026 Without SYNC_DEBOUNCE_FILTER_EN, no counters SHALL exist, out[i] SHALL register sync[i] every cycle (latency STAGES+1 posedges), and rise/fall SHALL still follow REQ-017..REQ-019.

Structure
REQ-027 Package sync_pkg SHALL hold the default values and legal minimums of WIDTH, STAGES and DEBOUNCE_CYCLES.
REQ-028 Sub-module sync_chan SHALL implement one channel (chain, counter, out, rise, fall); sync_debounce SHALL instantiate WIDTH copies via generate.
REQ-029 Elaboration SHALL raise $error if STAGES < 2 or DEBOUNCE_CYCLES < 2.

Verification (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-030 in=4'b0001 held after reset -> out=4'b0001 at posedge 6, rise=4'b0001 for one cycle only, fall=0.
REQ-031 in[1] high for 3 cycles then low -> out[1] stays 0, no rise/fall, counter returns to 0.
REQ-032 in 4'b0000->4'b1111 at once, then 4'b0000 after 10 cycles -> all channels rise together at posedge 6, fall together 6 posedges after the drop.
REQ-033 reset pulsed low at posedge 4 of a pending transition -> all outputs 0 immediately; transition completes 6 posedges after release.
REQ-034 Macro undefined, in=4'b0100 -> out=4'b0100 at posedge 3, with one rise[2] pulse.
REQ-035 Bench SHALL assert REQ-019 and one-cycle pulse width on every cycle of all scenarios.
